// File: rtl/decode.sv
// RV32I decode stage: registers one fetched instruction per cycle and emits decoded fields.
// Latency 1; stall_out holds fetch on a downstream stall or a load-use hazard, and flush overrides both.
module decode #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [INSTR_W-1:0] in_instr_i,
    input  logic [ADDR_W-1:0]  in_pc_i,
    input  logic               in_valid_i,
    output logic               stall_out_o,
    output logic [4:0]         rs1_addr_o,
    output logic [4:0]         rs2_addr_o,
    input  logic [31:0]        rs1_data_i,
    input  logic [31:0]        rs2_data_i,
    input  logic               stall_in_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    output logic [ADDR_W-1:0]  out_pc_o,
    output logic [4:0]         out_rd_o,
    output logic [31:0]        out_rs1_val_o,
    output logic [31:0]        out_rs2_val_o,
    output logic [31:0]        out_imm_o,
    output logic [2:0]         out_class_o,
    output logic [3:0]         out_alu_op_o,
    output logic [2:0]         out_funct3_o,
    output logic               out_illegal_o
);
    localparam logic [2:0] CLS_ALU_R = 3'd0, CLS_ALU_I = 3'd1, CLS_LOAD = 3'd2, CLS_STORE = 3'd3,
                           CLS_BRANCH = 3'd4, CLS_JAL = 3'd5, CLS_JALR = 3'd6, CLS_UPPER = 3'd7;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic {S_IDLE, S_BUBBLE} hz_state_e;
    hz_state_e state_q, state_d;

    logic              out_valid_q, out_valid_d, out_illegal_q, out_illegal_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic [31:0]       out_rs1_val_q, out_rs1_val_d, out_rs2_val_q, out_rs2_val_d;
    logic [31:0]       out_imm_q, out_imm_d;
    logic [2:0]        out_class_q, out_class_d, out_funct3_q, out_funct3_d;
    logic [3:0]        out_alu_op_q, out_alu_op_d;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [2:0]  dec_cls;
    logic [3:0]  dec_alu;
    logic [31:0] dec_imm;
    logic        dec_ill, dec_wb, uses_rs1, uses_rs2, hazard;

    assign opcode     = in_instr_i[6:0];
    assign f3         = in_instr_i[14:12];
    assign f7         = in_instr_i[31:25];
    assign rs1_addr_o = in_instr_i[19:15];
    assign rs2_addr_o = in_instr_i[24:20];

    assign imm_i = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_s = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
    assign imm_b = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                    in_instr_i[11:8], 1'b0};
    assign imm_u = {in_instr_i[31:12], 12'b0};
    assign imm_j = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                    in_instr_i[30:21], 1'b0};

    function automatic logic [3:0] base_alu(input logic [2:0] fn3);
        case (fn3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_cls = CLS_ALU_R;
        dec_alu = ALU_ADD;
        dec_imm = '0;
        dec_ill = 1'b0;
        dec_wb  = 1'b1;
        case (opcode)
            7'b0110011: begin
                if (f7 == 7'b0)                        dec_alu = base_alu(f3);
                else if (f7 == F7_ALT && f3 == 3'd0)   dec_alu = ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'd5)   dec_alu = ALU_SRA;
                else                                   dec_ill = 1'b1;
            end
            7'b0010011: begin
                dec_cls = CLS_ALU_I;
                dec_imm = imm_i;
                dec_alu = base_alu(f3);
                // Shifts reuse imm[11:5] as funct7, so only the shamt is passed on.
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    dec_imm = {27'b0, in_instr_i[24:20]};
                    if (f3 == 3'd5 && f7 == F7_ALT) dec_alu = ALU_SRA;
                    else if (f7 != 7'b0)            dec_ill = 1'b1;
                end
            end
            7'b0000011: begin
                dec_cls = CLS_LOAD;
                dec_imm = imm_i;
                dec_ill = (f3 == 3'd3) || (f3 > 3'd5);
            end
            7'b0100011: begin
                dec_cls = CLS_STORE;
                dec_imm = imm_s;
                dec_wb  = 1'b0;
                dec_ill = (f3 > 3'd2);
            end
            7'b1100011: begin
                dec_cls = CLS_BRANCH;
                dec_imm = imm_b;
                dec_wb  = 1'b0;
                dec_ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'b1101111: begin
                dec_cls = CLS_JAL;
                dec_imm = imm_j;
            end
            7'b1100111: begin
                dec_cls = CLS_JALR;
                dec_imm = imm_i;
                dec_ill = (f3 != 3'd0);
            end
            7'b0110111: begin
                dec_cls = CLS_UPPER;
                dec_imm = imm_u;
                dec_alu = ALU_PASS_B;
            end
            7'b0010111: begin
                dec_cls = CLS_UPPER;
                dec_imm = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign uses_rs1 = !dec_ill && dec_cls != CLS_JAL && dec_cls != CLS_UPPER;
    assign uses_rs2 = !dec_ill && (dec_cls == CLS_ALU_R || dec_cls == CLS_STORE || dec_cls == CLS_BRANCH);

    assign hazard = (state_q == S_IDLE) && out_valid_q && out_class_q == CLS_LOAD && out_rd_q != 5'd0
                 && in_valid_i && !stall_in_i && !flush_i
                 && ((uses_rs1 && rs1_addr_o == out_rd_q) || (uses_rs2 && rs2_addr_o == out_rd_q));

    assign stall_out_o = !reset_i && !flush_i && (stall_in_i || hazard);

    always_comb begin
        state_d       = S_IDLE;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_rd_d      = out_rd_q;
        out_rs1_val_d = out_rs1_val_q;
        out_rs2_val_d = out_rs2_val_q;
        out_imm_d     = out_imm_q;
        out_class_d   = out_class_q;
        out_alu_op_d  = out_alu_op_q;
        out_funct3_d  = out_funct3_q;
        out_illegal_d = out_illegal_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (!stall_in_i) begin
            if (hazard) begin
                out_valid_d = 1'b0;
                state_d     = S_BUBBLE;
            end else if (in_valid_i) begin
                out_valid_d   = 1'b1;
                out_pc_d      = in_pc_i;
                out_rd_d      = (dec_ill || !dec_wb) ? 5'd0 : in_instr_i[11:7];
                out_rs1_val_d = (rs1_addr_o == 5'd0) ? 32'd0 : rs1_data_i;
                out_rs2_val_d = (rs2_addr_o == 5'd0) ? 32'd0 : rs2_data_i;
                out_imm_d     = dec_imm;
                out_class_d   = dec_cls;
                out_alu_op_d  = dec_alu;
                out_funct3_d  = f3;
                out_illegal_d = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_rd_q      <= '0;
            out_rs1_val_q <= '0;
            out_rs2_val_q <= '0;
            out_imm_q     <= '0;
            out_class_q   <= '0;
            out_alu_op_q  <= '0;
            out_funct3_q  <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_rd_q      <= out_rd_d;
            out_rs1_val_q <= out_rs1_val_d;
            out_rs2_val_q <= out_rs2_val_d;
            out_imm_q     <= out_imm_d;
            out_class_q   <= out_class_d;
            out_alu_op_q  <= out_alu_op_d;
            out_funct3_q  <= out_funct3_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = out_pc_q;
    assign out_rd_o      = out_rd_q;
    assign out_rs1_val_o = out_rs1_val_q;
    assign out_rs2_val_o = out_rs2_val_q;
    assign out_imm_o     = out_imm_q;
    assign out_class_o   = out_class_q;
    assign out_alu_op_o  = out_alu_op_q;
    assign out_funct3_o  = out_funct3_q;
    assign out_illegal_o = out_illegal_q;
endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed scenarios followed by randomized instruction streams,
// each cycle checked against an instruction-level reference model.
module tb_decode;
    logic        clk = 1'b0;
    logic        reset, in_valid, stall_in, flush;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic        stall_out, out_valid, out_illegal;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [2:0]  out_class, out_funct3;
    logic [3:0]  out_alu_op;

    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    always #5 clk = ~clk;

    decode dut (
        .clk_i(clk), .reset_i(reset), .in_instr_i(in_instr), .in_pc_i(in_pc), .in_valid_i(in_valid),
        .stall_out_o(stall_out), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .stall_in_i(stall_in), .flush_i(flush),
        .out_valid_o(out_valid), .out_pc_o(out_pc), .out_rd_o(out_rd), .out_rs1_val_o(out_rs1_val),
        .out_rs2_val_o(out_rs2_val), .out_imm_o(out_imm), .out_class_o(out_class),
        .out_alu_op_o(out_alu_op), .out_funct3_o(out_funct3), .out_illegal_o(out_illegal)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1v, rs2v, imm;
        logic [2:0]  cls;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    exp_t        exp_q;
    int          n_checks = 0;
    int          n_err = 0;
    logic        last_stall;
    int unsigned alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    function automatic exp_t zero_exp();
        exp_t e;
        e.valid = 0; e.pc = 0; e.rd = 0; e.rs1v = 0; e.rs2v = 0; e.imm = 0;
        e.cls = 0; e.alu = 0; e.f3 = 0; e.ill = 0;
        return e;
    endfunction

    // Instruction-level meaning of one RV32I word, immediates via arithmetic shifts.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] v1, input logic [31:0] v2);
        exp_t e = zero_exp();
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [31:0] t;
        logic wb = 1;
        e.valid = 1; e.pc = pc; e.f3 = f3;
        e.rs1v = (ins[19:15] == 0) ? 32'd0 : v1;
        e.rs2v = (ins[24:20] == 0) ? 32'd0 : v2;
        t = ins;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 0) e.alu = 4'(alu_tab[f3]);
                else if (f7 == 7'h20 && f3 == 0) e.alu = 1;
                else if (f7 == 7'h20 && f3 == 5) e.alu = 7;
                else e.ill = 1;
            end
            7'h13: begin
                e.cls = 1;
                e.imm = $signed(t) >>> 20;
                e.alu = 4'(alu_tab[f3]);
                if (f3 == 1 || f3 == 5) begin
                    e.imm = {27'b0, ins[24:20]};
                    if (f3 == 5 && f7 == 7'h20) e.alu = 7;
                    else if (f7 != 0) e.ill = 1;
                end
            end
            7'h03: begin e.cls = 2; e.imm = $signed(t) >>> 20; e.ill = !(f3 inside {0, 1, 2, 4, 5}); end
            7'h23: begin
                e.cls = 3; wb = 0; e.ill = (f3 > 2);
                t = {ins[31:25], ins[11:7], 20'b0};
                e.imm = $signed(t) >>> 20;
            end
            7'h63: begin
                e.cls = 4; wb = 0; e.ill = (f3 == 2 || f3 == 3);
                t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0};
                e.imm = $signed(t) >>> 19;
            end
            7'h6F: begin
                e.cls = 5;
                t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0};
                e.imm = $signed(t) >>> 11;
            end
            7'h67: begin e.cls = 6; e.imm = $signed(t) >>> 20; e.ill = (f3 != 0); end
            7'h37: begin e.cls = 7; e.alu = 10; e.imm = ins & 32'hFFFFF000; end
            7'h17: begin e.cls = 7; e.alu = 0;  e.imm = ins & 32'hFFFFF000; end
            default: e.ill = 1;
        endcase
        e.rd = (e.ill || !wb) ? 5'd0 : ins[11:7];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.valid});
        if (exp_q.valid) begin
            chk("out_pc", out_pc, exp_q.pc);
            chk("out_rd", {27'b0, out_rd}, {27'b0, exp_q.rd});
            chk("out_rs1_val", out_rs1_val, exp_q.rs1v);
            chk("out_rs2_val", out_rs2_val, exp_q.rs2v);
            chk("out_funct3", {29'b0, out_funct3}, {29'b0, exp_q.f3});
            chk("out_illegal", {31'b0, out_illegal}, {31'b0, exp_q.ill});
            if (!exp_q.ill) begin
                chk("out_class", {29'b0, out_class}, {29'b0, exp_q.cls});
                chk("out_imm", out_imm, exp_q.imm);
                if (exp_q.cls != 4) chk("out_alu_op", {28'b0, out_alu_op}, {28'b0, exp_q.alu});
            end
        end
    endtask

    // One clock: check combinational outputs, predict the edge, then check registered outputs.
    task automatic step();
        exp_t cur, nxt;
        logic haz, exp_stall;
        #1;
        cur = ref_decode(in_instr, in_pc, regs[in_instr[19:15]], regs[in_instr[24:20]]);
        haz = exp_q.valid && exp_q.cls == 2 && exp_q.rd != 0 && in_valid && !stall_in && !flush
              && !cur.ill
              && ((cur.cls != 5 && cur.cls != 7 && in_instr[19:15] == exp_q.rd)
                  || (cur.cls inside {0, 3, 4} && in_instr[24:20] == exp_q.rd));
        exp_stall = !reset && !flush && (stall_in || haz);
        last_stall = stall_out;
        chk("stall_out", {31'b0, stall_out}, {31'b0, exp_stall});
        chk("rs1_addr", {27'b0, rs1_addr}, {27'b0, in_instr[19:15]});
        chk("rs2_addr", {27'b0, rs2_addr}, {27'b0, in_instr[24:20]});
        nxt = exp_q;
        if (reset) nxt = zero_exp();
        else if (flush) nxt.valid = 0;
        else if (stall_in) nxt = exp_q;
        else if (haz) nxt.valid = 0;
        else if (in_valid) nxt = cur;
        else nxt.valid = 0;
        @(posedge clk);
        #1;
        exp_q = nxt;
        check_outputs();
    endtask

    task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                         input logic vld, input logic stl, input logic fl);
        reset = rst; in_instr = ins; in_pc = pc; in_valid = vld; stall_in = stl; flush = fl;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 11);
        if (k < 9) begin
            w[6:0]   = ops[k];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    w[31:25] = 7'h00;
                2:       w[31:25] = 7'h20;
                default: w[31:25] = 7'($urandom);
            endcase
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        exp_q = zero_exp();
        last_stall = 0;

        // Reset with valid input and a downstream stall: stall_out must stay low.
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, $urandom, 1, (i == 1), 0);
            step();
        end
        chk("rst_pc", out_pc, 0);
        chk("rst_rd", {27'b0, out_rd}, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_rs1v", out_rs1_val, 0);
        chk("rst_rs2v", out_rs2_val, 0);
        chk("rst_cls", {29'b0, out_class}, 0);
        chk("rst_alu", {28'b0, out_alu_op}, 0);
        chk("rst_f3", {29'b0, out_funct3}, 0);
        chk("rst_ill", {31'b0, out_illegal}, 0);

        drive(0, 32'h00500093, 32'h10, 1, 0, 0); step();
        chk("addi_valid", {31'b0, out_valid}, 1);
        chk("addi_cls", {29'b0, out_class}, 1);
        chk("addi_alu", {28'b0, out_alu_op}, 0);
        chk("addi_rd", {27'b0, out_rd}, 1);
        chk("addi_imm", out_imm, 5);
        chk("addi_rs1v", out_rs1_val, 0);
        chk("addi_pc", out_pc, 32'h10);

        // Load-use: one stall cycle, one bubble, then the add.
        drive(0, 32'h0000A103, 32'h14, 1, 0, 0); step();
        drive(0, 32'h001101B3, 32'h18, 1, 0, 0); step();
        chk("lu_stall", {31'b0, last_stall}, 1);
        chk("lu_bubble", {31'b0, out_valid}, 0);
        step();
        chk("lu_stall2", {31'b0, last_stall}, 0);
        chk("lu_add_valid", {31'b0, out_valid}, 1);
        chk("lu_add_rd", {27'b0, out_rd}, 3);
        chk("lu_rs1a", {27'b0, rs1_addr}, 2);
        chk("lu_rs2a", {27'b0, rs2_addr}, 1);

        drive(0, 32'hFE208EE3, 32'h1C, 1, 0, 0); step();
        chk("beq_cls", {29'b0, out_class}, 4);
        chk("beq_rd", {27'b0, out_rd}, 0);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        drive(0, 32'hFFFFFFFF, 32'h20, 1, 0, 0); step();
        chk("ill_flag", {31'b0, out_illegal}, 1);
        chk("ill_valid", {31'b0, out_valid}, 1);
        chk("ill_rd", {27'b0, out_rd}, 0);

        // Downstream stall freezes outputs while fetch offers new words.
        drive(0, 32'h00500093, 32'h40, 1, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(0, gen_instr(), 32'h44 + 32'(4 * i), 1, 1, 0); step();
            chk("stall_pc", out_pc, 32'h40);
        end
        drive(0, 32'h00208133, 32'h60, 1, 0, 0); step();
        chk("unstall_pc", out_pc, 32'h60);

        // Flush beats stall and a pending hazard.
        drive(0, 32'h0000A103, 32'h64, 1, 0, 0); step();
        drive(0, 32'h001101B3, 32'h68, 1, 1, 1); step();
        chk("flush_stall_out", {31'b0, last_stall}, 0);
        chk("flush_valid", {31'b0, out_valid}, 0);
        drive(0, 32'h001101B3, 32'h68, 1, 0, 0); step();
        chk("post_flush_rd", {27'b0, out_rd}, 3);

        // Reset in the hazard cycle.
        drive(0, 32'h0000A103, 32'h70, 1, 0, 0); step();
        drive(1, 32'h001101B3, 32'h74, 1, 0, 0); step();
        chk("rst_haz_valid", {31'b0, out_valid}, 0);

        // Random stream; fetch holds its word while stall_out is high.
        drive(0, gen_instr(), 32'h100, 1, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            step();
            regs[$urandom_range(0, 31)] = $urandom;
            if (!last_stall || reset || flush) begin
                in_instr = gen_instr();
                in_pc    = in_pc + 4;
            end
            in_valid = ($urandom_range(0, 99) < 85);
            stall_in = ($urandom_range(0, 99) < 10);
            flush    = ($urandom_range(0, 99) < 5);
            reset    = ($urandom_range(0, 99) < 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
